alu_mac_acc: RTL and testbench

ALU_MAC_ACC -- requirements
Module: alu_mac_acc

---
 rtl/alu_mac_acc.sv | 135 +++++++++++++
 tb/tb_alu_mac_acc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mac_acc.sv
// alu_mac_acc -- multiply-accumulate back end.
// Sums a programmed number of unsigned 10-bit products into a saturating
// ACC_W-bit accumulator. The overflow flag is sticky for the whole job.
// The result is held under a valid/ready handshake.
module alu_mac_acc #(
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       term_count,
   input  logic [9:0]       product,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] acc_nxt_s;
   logic             ovf_r;
   logic             ovf_nxt_s;
   logic [3:0]       rem_r;
   logic [3:0]       rem_nxt_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;
   logic [ACC_W:0]   sat_s;

   // Saturating add. The MSB of the result flags that the sum was clipped.
   // The low ACC_W bits are the clipped sum.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [9:0]       b);
      logic [ACC_W:0] sum_v;
      sum_v = {1'b0, a} + {{(ACC_W-9){1'b0}}, b};
      if (sum_v[ACC_W]) begin
         return {1'b1, {ACC_W{1'b1}}};
      end else begin
         return {1'b0, sum_v[ACC_W-1:0]};
      end
   endfunction

   // Next-state and datapath update for the IDLE/ACCUM/DONE job sequencer.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      ovf_nxt_s   = ovf_r;
      rem_nxt_s   = rem_r;
      sat_s       = sat_add(acc_r, product);
      case (state_r)
         IDLE: begin
            if (start) begin
               acc_nxt_s = {ACC_W{1'b0}};
               ovf_nxt_s = 1'b0;
               if (term_count != 4'd0) begin
                  rem_nxt_s   = term_count;
                  state_nxt_s = ACCUM;
               end else begin
                  rem_nxt_s   = 4'd0;
                  state_nxt_s = DONE;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ACCUM: begin
            // In ACCUM in_ready is high, so in_valid alone marks a transfer.
            if (in_valid) begin
               acc_nxt_s = sat_s[ACC_W-1:0];
               ovf_nxt_s = ovf_r | sat_s[ACC_W];
               rem_nxt_s = rem_r - 4'd1;
               if (rem_r == 4'd1) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = ACCUM;
               end
            end else begin
               state_nxt_s = ACCUM;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            acc_nxt_s   = {ACC_W{1'b0}};
            ovf_nxt_s   = 1'b0;
            rem_nxt_s   = 4'd0;
         end
      endcase
   end

   // State, datapath and registered status outputs. Reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         acc_r       <= {ACC_W{1'b0}};
         ovf_r       <= 1'b0;
         rem_r       <= 4'd0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         acc_r       <= acc_nxt_s;
         ovf_r       <= ovf_nxt_s;
         rem_r       <= rem_nxt_s;
         in_ready_r  <= (state_nxt_s == ACCUM);
         out_valid_r <= (state_nxt_s == DONE);
         busy_r      <= (state_nxt_s != IDLE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign acc_out   = acc_r;
   assign overflow  = ovf_r;

endmodule

// File: tb/tb_alu_mac_acc.sv
// Self-checking bench for alu_mac_acc, built with a 12-bit accumulator.
// Expected results come from a job-level model.
// The result is the saturated total of the products, and overflow is set when that total exceeds the range.
module tb_alu_mac_acc;

   localparam int ACC_W = 12;
   localparam int MAX_V = (1 << ACC_W) - 1;
   localparam int LIMIT = 400;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [3:0]       term_count;
   logic [9:0]       product;
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] acc_out;
   logic             out_valid;
   logic             out_ready;
   logic             overflow;
   logic             busy;

   int checks = 0;
   int errors = 0;

   logic [9:0] prods_a [16];
   int         gaps_a  [16];

   alu_mac_acc #(.ACC_W(ACC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .term_count (term_count),
      .product    (product),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .acc_out    (acc_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Runs one job and waits for out_valid.
   // gaps_a[i] idle cycles come before product i.
   // anom counts cycles where in_ready or busy disagreed with an ACCUM job in progress.
   task automatic drive_job(input int n, output int lat, output logic [ACC_W-1:0] acc,
                            output logic ovf, output int anom, output logic tmo);
      int idx;
      int gap_left;
      int cyc;
      anom = 0;
      idx  = 0;
      @(negedge clk);
      start      = 1'b1;
      term_count = 4'(n);
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      @(negedge clk);
      start    = 1'b0;
      cyc      = 1;
      gap_left = (n > 0) ? gaps_a[0] : 0;
      while (out_valid !== 1'b1 && cyc < LIMIT) begin
         if (in_ready !== (idx < n)) anom++;
         if (busy !== 1'b1) anom++;
         if (idx < n && gap_left == 0) begin
            in_valid = 1'b1;
            product  = prods_a[idx];
            idx++;
            gap_left = (idx < n) ? gaps_a[idx] : 0;
         end else begin
            in_valid = 1'b0;
            product  = 10'($urandom);
            if (gap_left > 0) gap_left--;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      tmo = (out_valid !== 1'b1);
      lat = cyc;
      acc = acc_out;
      ovf = overflow;
   endtask

   // Hands the result to the consumer for one cycle.
   task automatic release_job();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (acc_out !== 12'd0) begin errors++; $display("FAIL reset_acc: got %0d expected 0", acc_out); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat; logic [ACC_W-1:0] acc; logic ovf; int anom; logic tmo;
      prods_a[0] = 10'd961; prods_a[1] = 10'd10; prods_a[2] = 10'd5;
      for (int i = 0; i < 16; i++) gaps_a[i] = 0;
      drive_job(3, lat, acc, ovf, anom, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout: no out_valid within %0d cycles", LIMIT); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
      checks++; if (acc !== 12'd976) begin errors++; $display("FAIL basic_acc: got %0d expected 976", acc); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
      checks++; if (anom !== 0) begin errors++; $display("FAIL basic_handshake: got %0d bad cycles expected 0", anom); end
      release_job();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %b expected 0", out_valid); end
      checks++; if (acc_out !== 12'd976) begin errors++; $display("FAIL basic_idle_hold: got %0d expected 976", acc_out); end
   endtask

   task automatic test_gaps();
      int lat; logic [ACC_W-1:0] acc; logic ovf; int anom; logic tmo;
      prods_a[0] = 10'd100; prods_a[1] = 10'd200;
      gaps_a[0] = 0; gaps_a[1] = 3;
      drive_job(2, lat, acc, ovf, anom, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL gaps_timeout: no out_valid within %0d cycles", LIMIT); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL gaps_latency: got %0d expected 6", lat); end
      checks++; if (acc !== 12'd300) begin errors++; $display("FAIL gaps_acc: got %0d expected 300", acc); end
      checks++; if (anom !== 0) begin errors++; $display("FAIL gaps_handshake: got %0d bad cycles expected 0", anom); end
      release_job();
   endtask

   task automatic test_saturate();
      int lat; logic [ACC_W-1:0] acc; logic ovf; int anom; logic tmo;
      for (int i = 0; i < 16; i++) begin prods_a[i] = 10'd1023; gaps_a[i] = 0; end
      drive_job(5, lat, acc, ovf, anom, tmo);
      checks++; if (acc !== 12'd4095) begin errors++; $display("FAIL sat_acc: got %0d expected 4095", acc); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", ovf); end
      release_job();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_idle_ovf: got %b expected 1", overflow); end
      prods_a[0] = 10'd7;
      drive_job(1, lat, acc, ovf, anom, tmo);
      checks++; if (acc !== 12'd7) begin errors++; $display("FAIL sat_next_acc: got %0d expected 7", acc); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_next_ovf: got %b expected 0", ovf); end
      release_job();
   endtask

   task automatic test_empty();
      int lat; logic [ACC_W-1:0] acc; logic ovf; int anom; logic tmo;
      for (int i = 0; i < 16; i++) begin prods_a[i] = 10'd1023; gaps_a[i] = 0; end
      drive_job(5, lat, acc, ovf, anom, tmo);
      release_job();
      drive_job(0, lat, acc, ovf, anom, tmo);
      checks++; if (lat !== 1) begin errors++; $display("FAIL empty_latency: got %0d expected 1", lat); end
      checks++; if (acc !== 12'd0) begin errors++; $display("FAIL empty_acc: got %0d expected 0", acc); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL empty_ovf: got %b expected 0", ovf); end
      for (int k = 0; k < 5; k++) begin
         start      = 1'b1;
         term_count = 4'd5;
         in_valid   = 1'b1;
         product    = 10'd99;
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL empty_hold_valid: cycle %0d got %b expected 1", k, out_valid); end
         checks++; if (acc_out !== 12'd0) begin errors++; $display("FAIL empty_hold_acc: cycle %0d got %0d expected 0", k, acc_out); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL empty_hold_ready: cycle %0d got %b expected 0", k, in_ready); end
      end
      start    = 1'b0;
      in_valid = 1'b0;
      release_job();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_release_busy: got %b expected 0", busy); end
   endtask

   task automatic test_idle_ignore();
      int lat; logic [ACC_W-1:0] acc; logic ovf; int anom; logic tmo;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         product  = 10'd500;
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", in_ready); end
      end
      prods_a[0] = 10'd1; prods_a[1] = 10'd2;
      gaps_a[0] = 0; gaps_a[1] = 0;
      drive_job(2, lat, acc, ovf, anom, tmo);
      checks++; if (acc !== 12'd3) begin errors++; $display("FAIL idle_ignore_acc: got %0d expected 3", acc); end
      release_job();
   endtask

   task automatic test_reset_mid();
      int lat; logic [ACC_W-1:0] acc; logic ovf; int anom; logic tmo;
      @(negedge clk);
      start = 1'b1; term_count = 4'd4;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; product = 10'd50;
      @(negedge clk);
      product = 10'd60;
      @(negedge clk);
      checks++; if (acc_out !== 12'd110) begin errors++; $display("FAIL mid_partial_acc: got %0d expected 110", acc_out); end
      product = 10'd70; rst = 1'b1; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      checks++; if (acc_out !== 12'd0) begin errors++; $display("FAIL mid_acc: got %0d expected 0", acc_out); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
      prods_a[0] = 10'd300; prods_a[1] = 10'd400; prods_a[2] = 10'd12;
      for (int i = 0; i < 16; i++) gaps_a[i] = 0;
      drive_job(3, lat, acc, ovf, anom, tmo);
      checks++; if (acc !== 12'd712) begin errors++; $display("FAIL mid_fresh_acc: got %0d expected 712", acc); end
      checks++; if (lat !== 4) begin errors++; $display("FAIL mid_fresh_latency: got %0d expected 4", lat); end
      release_job();
   endtask

   task automatic test_random();
      int lat; logic [ACC_W-1:0] acc; logic ovf; int anom; logic tmo;
      int n; int total; int gap_sum; int exp_acc; logic exp_ovf;
      for (int j = 0; j < 25; j++) begin
         n = int'($urandom_range(0, 15));
         total = 0;
         gap_sum = 0;
         for (int i = 0; i < 16; i++) begin
            prods_a[i] = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 200));
            gaps_a[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if (i < n) begin
               total   += int'(prods_a[i]);
               gap_sum += gaps_a[i];
            end
         end
         exp_ovf = (total > MAX_V);
         exp_acc = exp_ovf ? MAX_V : total;
         drive_job(n, lat, acc, ovf, anom, tmo);
         checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rand_timeout: job %0d no out_valid within %0d cycles", j, LIMIT); end
         checks++; if (int'(acc) !== exp_acc) begin errors++; $display("FAIL rand_acc: job %0d n=%0d got %0d expected %0d", j, n, acc, exp_acc); end
         checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL rand_ovf: job %0d got %b expected %b", j, ovf, exp_ovf); end
         checks++; if (lat !== n + 1 + gap_sum) begin errors++; $display("FAIL rand_latency: job %0d got %0d expected %0d", j, lat, n + 1 + gap_sum); end
         checks++; if (anom !== 0) begin errors++; $display("FAIL rand_handshake: job %0d got %0d bad cycles expected 0", j, anom); end
         release_job();
         checks++; if (int'(acc_out) !== exp_acc) begin errors++; $display("FAIL rand_idle_hold: job %0d got %0d expected %0d", j, acc_out, exp_acc); end
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      term_count = 4'd0;
      product    = 10'd0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_saturate();
      test_empty();
      test_idle_ignore();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
